serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//   Parametrised bit-serial WIDTH-bit subtractor: computes diff = a - b - bin, one bit per
//   clock, LSB first, through a single full-subtractor cell and a borrow flip-flop.
//   Multi-cycle successor to the combinational 1-bit full subtractor.
//   Adds a start/busy/done handshake, a borrow-out, and a signed-overflow flag.
//   Used where area matters more than latency (narrow datapaths, serial ALU slices).
// PARAMETERS
//   WIDTH  8  operand/result width in bits; legal range WIDTH >= 2
// PORTS
//   clk       in   1      rising-edge clock
//   rst_n     in   1      asynchronous active-low reset
//   start     in   1      request; sampled only in IDLE
//   a         in   WIDTH  minuend; captured on accepted start
//   b         in   WIDTH  subtrahend; captured on accepted start
//   bin       in   1      borrow-in; captured on accepted start
//   diff      out  WIDTH  result a - b - bin, modulo 2^WIDTH
//   bout      out  1      final borrow (1 = unsigned underflow)
//   overflow  out  1      signed (two's-complement) overflow of the subtraction
//   busy      out  1      high while in RUN
//   done      out  1      one-cycle completion pulse
// BEHAVIOUR
//   Reset (rst_n=0, async): state=IDLE; diff, bout, overflow, busy, done, bit counter,
//     operand and result shift regs, and borrow FF all 0. Any operation in progress is
//     discarded. Outputs go to 0 immediately; no done pulse follows.
//   FSM: IDLE -> RUN on start=1 at edge E0; RUN -> DONE after the WIDTH-th bit;
//     DONE -> IDLE unconditionally on the next edge.
//   Start acceptance: at E0 latch a, b into shift regs, borrow FF <= bin, count <= 0.
//     start is ignored in RUN and DONE: no effect, no queueing.
//   RUN, edges E1..E_WIDTH, one bit i per edge:
//     d  = a[i] ^ b[i] ^ br
//     br <= (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br)
//     d is shifted into the MSB of the internal result register; operand regs shift right.
//   Commit at E_WIDTH:
//     diff     <= full result
//     bout     <= final borrow
//     overflow <= (a[W-1] ^ b[W-1]) & (a[W-1] ^ diff[W-1]), using captured operands
//     Next state = DONE.
//   Output timing:
//     busy is 1 for exactly WIDTH cycles (E0 to E_WIDTH).
//     done is 1 for exactly 1 cycle (E_WIDTH to E_WIDTH+1).
//   Result stability: diff, bout and overflow change only at the commit edge. They hold the
//     previous result throughout RUN and until the next commit.
//   Earliest back-to-back start: the edge after done falls (E_WIDTH+1). Throughput is one
//     operation per WIDTH+2 cycles.
//   Operand changes after E0 have no effect on the result in flight.
//   bin=1 with a=b gives diff = all-ones and bout=1.
//   bin does not enter the overflow formula; overflow reflects the final signed result.
//   Bit counter is $clog2(WIDTH+1) bits and never wraps within an operation.
// TESTING
//   1. Reset: hold rst_n=0 for 3 cycles -> all outputs 0, busy=0.
//      Assert rst_n=0 mid-RUN -> busy/done drop asynchronously, diff=0, no later done.
//   2. W=8, a=0x05 b=0x03 bin=0 -> after 8 busy cycles, done 1 cycle:
//      diff=0x02, bout=0, overflow=0.
//   3. W=8, a=0x03 b=0x05 bin=0 -> diff=0xFE, bout=1, overflow=0.
//      W=8, a=0x00 b=0x00 bin=1 -> diff=0xFF, bout=1, overflow=0.
//   4. W=8, a=0x80 b=0x01 bin=0 -> diff=0x7F, bout=0, overflow=1.
//      W=8, a=0x7F b=0xFF bin=0 -> diff=0x80, bout=1, overflow=1.
//   5. Pulse start at E3 during RUN with new operands -> ignored, first result unchanged.
//      Start at E_WIDTH+1 -> accepted; diff holds the old value until the new commit.
//   6. W=4, exhaustive over all a, b, bin (512 cases):
//      {bout,diff} == (a - b - bin) mod 32, overflow matches the signed reference,
//      busy width == 4 cycles every time.

Source files
------------

// File: rtl/serial_subtractor_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : serial_subtractor_if                                            |
// | Purpose  : Bundles the request/result signals of serial_subtractor.        |
// |            master drives start/a/b/bin and observes the results;           |
// |            slave (the subtractor) takes the request and returns            |
// |            diff/bout/overflow/busy/done.                                   |
// | Signals  : start, a[WIDTH], b[WIDTH], bin   (master -> slave)              |
// |            diff[WIDTH], bout, overflow, busy, done   (slave -> master)     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface serial_subtractor_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic [WIDTH-1:0] diff;
   logic             bout;
   logic             overflow;
   logic             busy;
   logic             done;

   modport master (
      output start, a, b, bin,
      input  diff, bout, overflow, busy, done
   );

   modport slave (
      input  start, a, b, bin,
      output diff, bout, overflow, busy, done
   );
endinterface
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : serial_subtractor                                               |
// | Purpose  : Bit-serial WIDTH-bit subtractor, diff = a - b - bin, one bit    |
// |            per clock LSB first through a single full-subtractor cell and   |
// |            a borrow flip-flop, with start/busy/done handshake, borrow-out  |
// |            and signed-overflow flag.                                       |
// | Ports    : clk    rising-edge clock                                        |
// |            rst_n  asynchronous active-low reset                            |
// |            bus    serial_subtractor_if.slave                               |
// |                   start/a/b/bin in, diff/bout/overflow/busy/done out       |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  wire logic            clk,
   input  wire logic            rst_n,
   serial_subtractor_if.slave   bus
);

   localparam int              c_cw      = $clog2(WIDTH + 1);
   localparam logic [c_cw-1:0] c_last    = c_cw'(WIDTH - 1);

   localparam logic [1:0]      c_st_idle = 2'd0;
   localparam logic [1:0]      c_st_run  = 2'd1;
   localparam logic [1:0]      c_st_done = 2'd2;

   logic [1:0]       r_state;
   logic [c_cw-1:0]  r_cnt;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_res;
   logic             r_br;
   // Operand sign bits are kept aside because the operand regs are shifted
   // away by the time the overflow flag is computed.
   logic             r_a_msb;
   logic             r_b_msb;
   logic [WIDTH-1:0] r_diff;
   logic             r_bout;
   logic             r_ovf;
   logic             r_busy;
   logic             r_done;

   logic             w_d;
   logic             w_br_nxt;
   logic [WIDTH-1:0] w_res_nxt;

   // Full-subtractor cell on the current LSBs.
   assign w_d       = r_a[0] ^ r_b[0] ^ r_br;
   assign w_br_nxt  = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
   // On the last bit this is already the complete result, so commit uses it
   // directly instead of waiting one more cycle for r_res.
   assign w_res_nxt = {w_d, r_res[WIDTH-1:1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= c_st_idle;
         r_cnt   <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_res   <= '0;
         r_br    <= 1'b0;
         r_a_msb <= 1'b0;
         r_b_msb <= 1'b0;
         r_diff  <= '0;
         r_bout  <= 1'b0;
         r_ovf   <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            c_st_idle: begin
               if (bus.start) begin
                  r_a     <= bus.a;
                  r_b     <= bus.b;
                  r_br    <= bus.bin;
                  r_a_msb <= bus.a[WIDTH-1];
                  r_b_msb <= bus.b[WIDTH-1];
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= c_st_run;
               end
            end
            c_st_run: begin
               r_br  <= w_br_nxt;
               r_a   <= r_a >> 1;
               r_b   <= r_b >> 1;
               r_res <= w_res_nxt;
               // Counts up to WIDTH at most, which fits c_cw bits.
               r_cnt <= r_cnt + c_cw'(1);
               if (r_cnt == c_last) begin
                  r_diff  <= w_res_nxt;
                  r_bout  <= w_br_nxt;
                  r_ovf   <= (r_a_msb ^ r_b_msb) & (r_a_msb ^ w_d);
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= c_st_done;
               end
            end
            c_st_done: begin
               r_done  <= 1'b0;
               r_state <= c_st_idle;
            end
            default: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= c_st_idle;
            end
         endcase
      end
   end

   assign bus.diff     = r_diff;
   assign bus.bout     = r_bout;
   assign bus.overflow = r_ovf;
   assign bus.busy     = r_busy;
   assign bus.done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_serial_subtractor                                            |
// | Purpose  : Self-checking bench for serial_subtractor: directed 8-bit       |
// |            vectors, start-ignore, back-to-back and reset corner cases,     |
// |            plus an exhaustive 4-bit sweep against an arithmetic reference. |
// | Ports    : none                                                            |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_serial_subtractor;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   serial_subtractor_if #(.WIDTH(8)) bus8 ();
   serial_subtractor_if #(.WIDTH(4)) bus4 ();

   serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
   serial_subtractor #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       bin;
      logic [7:0] diff;
      logic       bout;
      logic       ovf;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Called at a negedge with the DUT idle; returns at the negedge after
   // done has fallen, so an immediate second call starts back-to-back.
   task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                       input logic [7:0] exp_diff, input logic exp_bout, input logic exp_ovf,
                       input bit inject, input bit chk_hold, input logic [7:0] hold_diff);
      int n;
      bus8.start = 1'b1;
      bus8.a     = a;
      bus8.b     = b;
      bus8.bin   = bin;
      @(negedge clk);
      bus8.start = 1'b0;
      n = 0;
      while (bus8.busy === 1'b1 && n < 40) begin
         n++;
         if (chk_hold) chk("diff_hold", 32'(bus8.diff), 32'(hold_diff));
         if (inject && n == 3) begin
            bus8.start = 1'b1;
            bus8.a     = 8'h80;
            bus8.b     = 8'h01;
            bus8.bin   = 1'b1;
         end else begin
            bus8.start = 1'b0;
            bus8.a     = 8'hC3;
            bus8.b     = 8'h3C;
            bus8.bin   = 1'b0;
         end
         @(negedge clk);
      end
      bus8.start = 1'b0;
      chk("busy_width8", 32'(n), 32'd8);
      chk("done_pulse", 32'(bus8.done), 32'd1);
      chk("diff8", 32'(bus8.diff), 32'(exp_diff));
      chk("bout8", 32'(bus8.bout), 32'(exp_bout));
      chk("ovf8", 32'(bus8.overflow), 32'(exp_ovf));
      @(negedge clk);
      chk("done_fall", 32'(bus8.done), 32'd0);
   endtask

   task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic bin);
      int         n;
      int         r;
      logic [4:0] ref_full;
      logic       ref_ovf;
      bus4.start = 1'b1;
      bus4.a     = a;
      bus4.b     = b;
      bus4.bin   = bin;
      @(negedge clk);
      bus4.start = 1'b0;
      n = 0;
      while (bus4.busy === 1'b1 && n < 20) begin
         n++;
         @(negedge clk);
      end
      ref_full = 5'(int'(a) - int'(b) - int'(bin));
      r        = int'($signed(a)) - int'($signed(b)) - int'(bin);
      ref_ovf  = (r < -8) || (r > 7);
      chk("busy_width4", 32'(n), 32'd4);
      chk("done4", 32'(bus4.done), 32'd1);
      chk("full4", 32'({bus4.bout, bus4.diff}), 32'(ref_full));
      chk("ovf4", 32'(bus4.overflow), 32'(ref_ovf));
      @(negedge clk);
   endtask

   initial begin
      bit saw_done;
      checks = 0;
      errors = 0;

      vecs[0] = '{a: 8'h05, b: 8'h03, bin: 1'b0, diff: 8'h02, bout: 1'b0, ovf: 1'b0};
      vecs[1] = '{a: 8'h03, b: 8'h05, bin: 1'b0, diff: 8'hFE, bout: 1'b1, ovf: 1'b0};
      vecs[2] = '{a: 8'h00, b: 8'h00, bin: 1'b1, diff: 8'hFF, bout: 1'b1, ovf: 1'b0};
      vecs[3] = '{a: 8'h80, b: 8'h01, bin: 1'b0, diff: 8'h7F, bout: 1'b0, ovf: 1'b1};
      vecs[4] = '{a: 8'h7F, b: 8'hFF, bin: 1'b0, diff: 8'h80, bout: 1'b1, ovf: 1'b1};
      vecs[5] = '{a: 8'hFF, b: 8'hFF, bin: 1'b1, diff: 8'hFF, bout: 1'b1, ovf: 1'b0};
      vecs[6] = '{a: 8'h7F, b: 8'h80, bin: 1'b0, diff: 8'hFF, bout: 1'b1, ovf: 1'b1};
      vecs[7] = '{a: 8'hA5, b: 8'h5A, bin: 1'b1, diff: 8'h4A, bout: 1'b0, ovf: 1'b1};

      bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.bin = 1'b0;
      bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.bin = 1'b0;

      // Reset held for three cycles.
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_diff", 32'(bus8.diff), 32'd0);
      chk("rst_bout", 32'(bus8.bout), 32'd0);
      chk("rst_ovf", 32'(bus8.overflow), 32'd0);
      chk("rst_busy", 32'(bus8.busy), 32'd0);
      chk("rst_done", 32'(bus8.done), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed vectors.
      for (int i = 0; i < 8; i++)
         run8(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].diff, vecs[i].bout, vecs[i].ovf,
              1'b0, 1'b0, 8'h00);

      // Start pulse with new operands in the middle of RUN is ignored.
      run8(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
      // Back-to-back: next start at the earliest edge; old result held in RUN.
      run8(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0, 1'b1, 8'h02);
      run8(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b1, 8'hFE);

      // Reset asserted mid-RUN: outputs drop without waiting for a clock.
      bus8.start = 1'b1; bus8.a = 8'h05; bus8.b = 8'h03; bus8.bin = 1'b0;
      @(negedge clk);
      bus8.start = 1'b0;
      repeat (2) @(negedge clk);
      chk("mid_busy_before", 32'(bus8.busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", 32'(bus8.busy), 32'd0);
      chk("mid_rst_done", 32'(bus8.done), 32'd0);
      chk("mid_rst_diff", 32'(bus8.diff), 32'd0);
      chk("mid_rst_ovf", 32'(bus8.overflow), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      saw_done = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (bus8.done === 1'b1 || bus8.busy === 1'b1) saw_done = 1'b1;
      end
      chk("no_done_after_rst", 32'(saw_done), 32'd0);

      // Exhaustive 4-bit sweep.
      for (int a = 0; a < 16; a++)
         for (int b = 0; b < 16; b++)
            for (int c = 0; c < 2; c++)
               run4(4'(a), 4'(b), 1'(c));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
